// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
//   Shares one AES encryption core between two requesters. Each requester
//   hands over a key/plaintext pair on a valid/ready handshake. Grants
//   alternate round-robin when both requesters contend. The arbiter loads the
//   core, waits for its done pulse, and returns the ciphertext tagged with the
//   owning requester on a single response channel. If done never comes, the
//   response is an error with zero data.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   reqN_valid/ready         request handshake (N = 0, 1); ready is combinational in IDLE
//   reqN_key, reqN_text      128-bit key and plaintext of requester N
//   rsp_valid/ready          response handshake
//   rsp_data, rsp_id, rsp_err  ciphertext (0 on error), owner, timeout flag
//   core_ld, core_key, core_text  load strobe and operands to the AES core
//   core_done, core_text_out      done pulse and ciphertext from the AES core
module aes_core_arbiter #(
    parameter int TIMEOUT = 31,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_text,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_text,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         rsp_err,
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text,
    input  logic         core_done,
    input  logic [127:0] core_text_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   text_q, text_d;
    logic [127:0]   rsp_data_q, rsp_data_d;
    logic           rsp_id_q, rsp_id_d;
    logic           rsp_err_q, rsp_err_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           core_ld_q, core_ld_d;

    logic           grant_valid;
    logic           grant_id;
    logic [CW-1:0]  cnt_inc;

    // Grant decision: only meaningful in IDLE. Under contention the
    // requester that did not win last time gets the core.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Ready is masked by reset so no handshake can complete while reset is held.
    assign req0_ready = grant_valid && !grant_id && !rst;
    assign req1_ready = grant_valid &&  grant_id && !rst;

    // cnt_inc is the number of BUSY cycles including the current one, so the
    // timeout response becomes visible exactly TIMEOUT cycles after core_ld.
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        text_d       = text_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        rsp_valid_d  = rsp_valid_q;
        core_ld_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    key_d        = grant_id ? req1_key  : req0_key;
                    text_d       = grant_id ? req1_text : req0_text;
                    rsp_id_d     = grant_id;
                    last_grant_d = grant_id;
                    core_ld_d    = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                // A done pulse here belongs to no job of ours and is dropped.
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                cnt_d = cnt_inc;
                if (core_done) begin
                    rsp_data_d  = core_text_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_inc == CW'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            key_q        <= '0;
            text_q       <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            core_ld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            text_q       <= text_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            core_ld_q    <= core_ld_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign core_ld   = core_ld_q;
    assign core_key  = key_q;
    assign core_text = text_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter
//   Directed testbench for aes_core_arbiter. A small behavioural stand-in for
//   the AES core raises done 11 cycles after core_ld. It returns the FIPS-197
//   ciphertext for the FIPS-197 vector and a simple mixing function otherwise.
module tb_aes_core_arbiter;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BOGUS_CT = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_key, req0_text, req1_key, req1_text;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_id, rsp_err;
    logic         core_ld;
    logic [127:0] core_key, core_text;
    logic         core_done;
    logic [127:0] core_text_out;

    // core model state
    logic         mdl_busy, model_done, no_done, inj_done;
    logic [3:0]   mdl_cnt;
    logic [127:0] mdl_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_core_arbiter #(.TIMEOUT(31)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_key(req0_key), .req0_text(req0_text),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_key(req1_key), .req1_text(req1_text),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .core_ld(core_ld), .core_key(core_key), .core_text(core_text),
        .core_done(core_done), .core_text_out(core_text_out)
    );

    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ {t[63:0], t[127:64]} ^ 128'h5a;
    endfunction

    // AES core stand-in: done is visible 11 cycles after the core_ld cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_busy   <= 1'b0;
            mdl_cnt    <= '0;
            model_done <= 1'b0;
            mdl_out    <= '0;
        end else begin
            model_done <= 1'b0;
            if (core_ld) begin
                mdl_busy <= 1'b1;
                mdl_cnt  <= '0;
                mdl_out  <= core_fn(core_key, core_text);
            end else if (mdl_busy) begin
                mdl_cnt <= mdl_cnt + 4'd1;
                if (mdl_cnt == 4'd9) begin
                    mdl_busy   <= 1'b0;
                    model_done <= !no_done;
                end
            end
        end
    end

    assign core_done     = model_done | inj_done;
    assign core_text_out = inj_done ? BOGUS_CT : mdl_out;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a lone request, wait for its ready, and step over the accept edge.
    // Returns one cycle after the accept (the LOAD cycle).
    task automatic send(input logic id, input logic [127:0] k, input logic [127:0] t);
        int guard;
        guard = 0;
        if (id) begin req1_valid = 1'b1; req1_key = k; req1_text = t; end
        else    begin req0_valid = 1'b1; req0_key = k; req0_text = t; end
        #1;
        while (!(id ? req1_ready : req0_ready) && guard < 100) begin
            tick();
            guard++;
        end
        check("ready_seen", id ? req1_ready : req0_ready, 1'b1);
        tick();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Poll for rsp_valid with a bound; n counts cycles from 'start', lds counts core_ld cycles.
    task automatic wait_rsp(input int start, output int n, output int lds);
        n   = start;
        lds = 0;
        while (!rsp_valid && n < 100) begin
            if (core_ld) lds++;
            tick();
            n++;
        end
        if (!rsp_valid) check("rsp_wait_expired", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lds, g, c0, c1;
        logic [127:0] ek, et, held;
        logic stable;

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_key = '0; req0_text = '0; req1_key = '0; req1_text = '0;
        no_done = 0; inj_done = 0;
        tick();
        tick();
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_core_ld", core_ld, 1'b0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_rsp_id_err", {rsp_id, rsp_err}, 2'b00);
        check("rst_core_key", core_key, '0);
        rst = 1'b0;

        // 1: FIPS vector on requester 0
        rsp_ready = 1'b1;
        send(1'b0, FIPS_KEY, FIPS_PT);
        check("t1_ld_at_T1", core_ld, 1'b1);
        wait_rsp(1, n, lds);
        check("t1_latency", n, 13);
        check("t1_ld_count", lds, 1);
        check("t1_data", rsp_data, FIPS_CT);
        check("t1_id", rsp_id, 1'b0);
        check("t1_err", rsp_err, 1'b0);
        tick();
        check("t1_consumed", rsp_valid, 1'b0);

        // 2: continuous contention from reset, 4 jobs each
        do_reset();
        c0 = 0; c1 = 0;
        for (int j = 0; j < 8; j++) begin
            req0_key  = {4{32'h1000_0000 + 32'(c0)}};
            req0_text = {4{32'h2000_0000 + 32'(c0)}};
            req1_key  = {4{32'h3000_0000 + 32'(c1)}};
            req1_text = {4{32'h4000_0000 + 32'(c1)}};
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 100) begin
                tick();
                n++;
            end
            g = int'(req1_ready);
            check("t2_grant_order", g, j % 2);
            check("t2_single_ready", req0_ready & req1_ready, 1'b0);
            ek = (g != 0) ? req1_key : req0_key;
            et = (g != 0) ? req1_text : req0_text;
            tick();
            if (j == 7) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            if (g != 0) c1++; else c0++;
            wait_rsp(1, n, lds);
            check("t2_ld_count", lds, 1);
            check("t2_id", rsp_id, g[0]);
            check("t2_data", rsp_data, core_fn(ek, et));
            tick();
        end

        // 3: backpressure, and no accept in the rsp_ready cycle
        rsp_ready = 1'b0;
        send(1'b0, 128'h0123, 128'h4567);
        wait_rsp(1, n, lds);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_key   = 128'h89ab;
        req1_text  = 128'hcdef;
        #1;
        held = core_fn(128'h0123, 128'h4567);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!(rsp_valid && rsp_data == held && rsp_id == 1'b0 && !req0_ready && !req1_ready))
                stable = 1'b0;
            tick();
        end
        check("t3_held_stable", stable, 1'b1);
        rsp_ready = 1'b1;
        #1;
        check("t3_no_ready_in_rsp", {req0_ready, req1_ready}, 2'b00);
        tick();
        check("t3_next_grant", {req0_ready, req1_ready}, 2'b01);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(1, n, lds);
        check("t3_next_id", rsp_id, 1'b1);
        check("t3_next_data", rsp_data, core_fn(128'h89ab, 128'hcdef));
        tick();

        // 4: core never finishes
        no_done = 1'b1;
        send(1'b0, 128'h1111, 128'h2222);
        wait_rsp(0, n, lds);
        check("t4_timeout_cycles", n, 31);
        check("t4_err", rsp_err, 1'b1);
        check("t4_data_zero", rsp_data, '0);
        check("t4_id", rsp_id, 1'b0);
        tick();
        no_done = 1'b0;
        send(1'b1, 128'h3333, 128'h4444);
        wait_rsp(1, n, lds);
        check("t4_recover_err", rsp_err, 1'b0);
        check("t4_recover_data", rsp_data, core_fn(128'h3333, 128'h4444));
        tick();

        // 5: stray done pulses in LOAD and RESP
        rsp_ready = 1'b0;
        send(1'b0, 128'h5555, 128'h6666);
        check("t5_in_load", core_ld, 1'b1);
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        wait_rsp(2, n, lds);
        check("t5_latency", n, 13);
        check("t5_data", rsp_data, core_fn(128'h5555, 128'h6666));
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        check("t5_resp_data_kept", rsp_data, core_fn(128'h5555, 128'h6666));
        check("t5_resp_still_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        tick();

        // 6: reset in BUSY
        send(1'b0, 128'h7777, 128'h8888);
        for (int i = 0; i < 5; i++) tick();
        req0_valid = 1'b1; req0_key = 128'h9999; req0_text = 128'haaaa;
        req1_valid = 1'b1; req1_key = 128'hbbbb; req1_text = 128'hcccc;
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", {rsp_valid, core_ld, req0_ready, req1_ready, rsp_id, rsp_err}, 6'b0);
        check("t6_rst_data", rsp_data, '0);
        check("t6_rst_core_key", core_key, '0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t6_first_grant", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(1, n, lds);
        check("t6_latency", n, 13);
        check("t6_ld_count", lds, 1);
        check("t6_id", rsp_id, 1'b0);
        check("t6_data", rsp_data, core_fn(128'h9999, 128'haaaa));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
Shares one aes_cipher_top encryption core between two independent requesters. Each requester supplies a 128-bit key and plaintext over a valid/ready handshake. Grants alternate round-robin, and the block drives the core's ld/key/text_in and waits for done. It returns the ciphertext with the requester ID on a single response channel and flags an error if the core never asserts done.

Parameters:
TIMEOUT, 31, maximum cycles in BUSY waiting for core_done before an error response; legal 13..255
CW, $clog2(TIMEOUT+1), busy-counter width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a job
req0_ready  out  1  requester 0 job accepted this cycle
req0_key  in  128  requester 0 key
req0_text  in  128  requester 0 plaintext
req1_valid  in  1  requester 1 has a job
req1_ready  out  1  requester 1 job accepted this cycle
req1_key  in  128  requester 1 key
req1_text  in  128  requester 1 plaintext
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  128  ciphertext (0 on error)
rsp_id  out  1  requester that owns the response
rsp_err  out  1  1 = timeout, no valid ciphertext
core_ld  out  1  load strobe to the AES core
core_key  out  128  key to the AES core
core_text  out  128  plaintext to the AES core
core_done  in  1  one-cycle done pulse from the AES core
core_text_out  in  128  ciphertext from the AES core

Behaviour:
- Reset (async, asserted):
  - state=IDLE, last_grant=1 (requester 0 wins the first contention), busy counter=0.
  - Key/text/rsp_data registers cleared to 0; rsp_id=0, rsp_err=0.
  - All outputs 0: rsp_valid, core_ld, req*_ready.
  - Reset mid-operation abandons the job with no response; the core is not re-loaded.
- FSM states: IDLE, LOAD, BUSY, RESP.
- IDLE:
  - grant is combinational. If exactly one reqN_valid, grant N. If both, grant the requester != last_grant.
  - reqN_ready = grant==N, asserted only in IDLE. The handshake completes on valid&ready.
  - On transfer: register key, text and id=N; set last_grant=N; go to LOAD.
  - No valid: stay in IDLE.
  - The ready/valid path is combinational in IDLE. Requesters must not make valid depend on ready.
- LOAD:
  - core_ld=1 for exactly this one cycle; counter cleared; go to BUSY.
  - core_done seen in LOAD is ignored, as a stale pulse.
- BUSY:
  - core_ld=0; counter increments each cycle.
  - core_done=1: capture core_text_out into rsp_data, rsp_err=0, go to RESP.
  - Else, counter==TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
  - done and the timeout in the same cycle: done wins.
- core_key/core_text are driven from the registered copies in every state. They hold stable from LOAD until the next accept.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err held stable until rsp_ready.
  - When rsp_ready: go to IDLE. No new request is accepted in the same cycle.
  - Backpressure of any length is legal; core_done pulses during RESP are ignored.
- Latency: accept at cycle T, core_ld at T+1, rsp_valid the cycle after core_done. For the standard 128-bit core, rsp_valid is at T+13.
- Throughput: one job in flight. Minimum occupancy is accept + 1 + core latency + 1 response cycle.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1. A lone requester may be granted back-to-back.

Test Plan:
1. Reset, then req0 with key 000102030405060708090a0b0c0d0e0f and text 00112233445566778899aabbccddeeff, rsp_ready=1 -> core_ld is a single pulse at T+1. Response is 69c4e0d86a7b0430d8cdb78070b4c55a with rsp_id=0 and rsp_err=0.
2. req0 and req1 both valid from reset, 4 jobs each -> accept order is 0,1,0,1,… Each rsp_id matches its job, and no second core_ld occurs before the prior response is consumed.
3. Hold rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid, data and id stay stable. Both req*_ready stay 0, and the next accept occurs only after the rsp_ready cycle.
4. Bench core model never asserts done, TIMEOUT=31 -> rsp_valid arrives 31 cycles after core_ld with rsp_err=1 and rsp_data=0. The next job then proceeds normally.
5. Inject a core_done pulse during LOAD and during RESP -> both are ignored. The response carries the ciphertext of the real done.
6. Assert rst in BUSY, 5 cycles after core_ld -> all outputs are 0 immediately, with no response for the aborted job. After release, a simultaneous req0+req1 is granted to req0.
